// File: rtl/bridge_tc.sv
// bridge_tc: M-stage system bridge decoding CPU accesses to data memory, two timer/counters
// and the interrupt-generator ack word. Define BRIDGE_TC1_EN to instantiate the second timer.

module bridge_tc_timer (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_idx_i,
    input  logic [31:0] wr_data_i,
    input  logic [1:0]  rd_idx_i,
    output logic [31:0] rd_data_o,
    output logic        irq_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} tc_state_e;

    tc_state_e   state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_q;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (ctrl_q[0]) state_q <= ST_LOAD;
                ST_LOAD: begin
                    count_q <= (preset_q == 32'd0) ? 32'd1 : preset_q;
                    state_q <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_q[0]) begin
                        state_q <= ST_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q <= 32'd0;
                        irq_q   <= 1'b1;
                        state_q <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (ctrl_q[2:1] == 2'b01) begin
                        irq_q   <= 1'b0;
                        state_q <= ST_LOAD;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // NOTE: the CPU write is placed after the FSM so its non-blocking update wins in the same cycle.
            if (wr_en_i) begin
                case (wr_idx_i)
                    2'd0: begin
                        ctrl_q <= wr_data_i[3:0];
                        irq_q  <= 1'b0;
                    end
                    2'd1:    preset_q <= wr_data_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (rd_idx_i)
            2'd0:    rd_data_o = {28'd0, ctrl_q};
            2'd1:    rd_data_o = preset_q;
            2'd2:    rd_data_o = count_q;
            default: rd_data_o = 32'd0;
        endcase
    end

    assign irq_o = irq_q & ctrl_q[3];
endmodule

module bridge_tc #(
    parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
    parameter logic [31:0] IG_BASE  = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        Req,
    input  logic [3:0]  BridgeSel,
    input  logic        ISLOADSTORE,
    input  logic [31:0] A,
    input  logic [31:0] D,
    output logic [31:0] Q,
    output logic [1:0]  AdE,
    output logic [5:0]  HWInt,
    output logic [31:0] DM_A,
    output logic [3:0]  DM_BE,
    output logic [31:0] DM_D,
    input  logic [31:0] DM_Q,
    input  logic        EXT_IRQ,
    output logic        IG_ACK
);
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE, SZ_RSVD} size_e;

    size_e       size;
    logic        is_store;
    logic        in_dm, in_tc0, in_tc1, in_tc1_win, in_ig;
    logic        misalign, tc_fault, fault, wr_ok;
    logic [3:0]  be;
    logic [31:0] tc0_rd, tc1_rd, rd_word, shifted, ext;
    logic        tc0_irq, tc1_irq;

    assign size     = size_e'(BridgeSel[1:0]);
    assign is_store = BridgeSel[3];

    // Unsigned offset compare covers both window bounds at once.
    assign in_dm      = (A <= DM_TOP);
    assign in_tc0     = ((A - TC0_BASE) < 32'd12);
    assign in_tc1_win = ((A - TC1_BASE) < 32'd12);
    assign in_ig      = ((A - IG_BASE) < 32'd4);

    assign misalign = ((size == SZ_WORD) && (A[1:0] != 2'b00)) ||
                      ((size == SZ_HALF) && A[0]) || (size == SZ_RSVD);
    assign tc_fault = (in_tc0 || in_tc1) &&
                      ((size != SZ_WORD) || (is_store && (A[3:2] == 2'b10)));
    assign fault    = ISLOADSTORE &&
                      (misalign || tc_fault || !(in_dm || in_tc0 || in_tc1 || in_ig));
    assign AdE      = fault ? (is_store ? 2'b10 : 2'b01) : 2'b00;
    assign wr_ok    = ISLOADSTORE && is_store && !fault && !Req;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        be   = 4'b1111;
        DM_D = D;
        case (size)
            SZ_HALF: begin
                be   = 4'b0011 << {A[1], 1'b0};
                DM_D = {2{D[15:0]}};
            end
            SZ_BYTE: begin
                be   = 4'b0001 << A[1:0];
                DM_D = {4{D[7:0]}};
            end
            default: ;
        endcase
    end

    assign DM_A   = {A[31:2], 2'b00};
    assign DM_BE  = (wr_ok && in_dm) ? be : 4'b0000;
    assign IG_ACK = wr_ok && in_ig;

    always_comb begin
        rd_word = 32'd0;
        if (in_dm)       rd_word = DM_Q;
        else if (in_tc0) rd_word = tc0_rd;
        else if (in_tc1) rd_word = tc1_rd;
        shifted = rd_word >> {A[1:0], 3'b000};
        case (size)
            SZ_HALF: ext = BridgeSel[2] ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            SZ_BYTE: ext = BridgeSel[2] ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            default: ext = shifted;
        endcase
    end

    assign Q = (ISLOADSTORE && !is_store && !fault) ? ext : 32'd0;

    bridge_tc_timer u_tc0 (
        .clk       (clk),
        .RESET_N   (RESET_N),
        .wr_en_i   (wr_ok && in_tc0),
        .wr_idx_i  (A[3:2]),
        .wr_data_i (D),
        .rd_idx_i  (A[3:2]),
        .rd_data_o (tc0_rd),
        .irq_o     (tc0_irq)
    );

`ifdef BRIDGE_TC1_EN
    assign in_tc1 = in_tc1_win;

    bridge_tc_timer u_tc1 (
        .clk       (clk),
        .RESET_N   (RESET_N),
        .wr_en_i   (wr_ok && in_tc1),
        .wr_idx_i  (A[3:2]),
        .wr_data_i (D),
        .rd_idx_i  (A[3:2]),
        .rd_data_o (tc1_rd),
        .irq_o     (tc1_irq)
    );
`else
    // Window still decoded but never claimed, so TC1 accesses fall through to an address fault.
    assign in_tc1  = in_tc1_win & 1'b0;
    assign tc1_rd  = 32'd0;
    assign tc1_irq = 1'b0;
`endif

    assign HWInt = {3'b000, EXT_IRQ, tc1_irq, tc0_irq};
endmodule

// File: tb/tb_bridge_tc.sv
// Directed-vector bench for bridge_tc: DM load/store lanes, address faults, Req gating,
// IG acknowledge, TC0 one-shot / auto-reload timing and asynchronous reset mid-count.

module tb_bridge_tc;
    logic        clk = 1'b0;
    logic        RESET_N, Req, ISLOADSTORE, EXT_IRQ, IG_ACK;
    logic [3:0]  BridgeSel, DM_BE;
    logic [31:0] A, D, Q, DM_A, DM_D, DM_Q;
    logic [1:0]  AdE;
    logic [5:0]  HWInt;
    logic [31:0] mem [0:1023];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    bridge_tc dut (
        .clk         (clk),
        .RESET_N     (RESET_N),
        .Req         (Req),
        .BridgeSel   (BridgeSel),
        .ISLOADSTORE (ISLOADSTORE),
        .A           (A),
        .D           (D),
        .Q           (Q),
        .AdE         (AdE),
        .HWInt       (HWInt),
        .DM_A        (DM_A),
        .DM_BE       (DM_BE),
        .DM_D        (DM_D),
        .DM_Q        (DM_Q),
        .EXT_IRQ     (EXT_IRQ),
        .IG_ACK      (IG_ACK)
    );

    // Data memory behind the bridge
    assign DM_Q = mem[DM_A[11:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (DM_BE[b]) mem[DM_A[11:2]][b*8 +: 8] <= DM_D[b*8 +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // sel = {store, unsigned, size[1:0]}
    task automatic acc(input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] data);
        BridgeSel   = sel;
        A           = addr;
        D           = data;
        ISLOADSTORE = 1'b1;
        #1;
    endtask

    task automatic idle();
        ISLOADSTORE = 1'b0;
        BridgeSel   = 4'd0;
        A           = 32'd0;
        D           = 32'd0;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] LW = 4'b0000, LH = 4'b0001, LB = 4'b0010;
    localparam logic [3:0] LHU = 4'b0101, LBU = 4'b0110;
    localparam logic [3:0] SW = 4'b1000, SH = 4'b1001, SB = 4'b1010;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        RESET_N = 1'b0; Req = 1'b0; EXT_IRQ = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hwint", {26'd0, HWInt}, 32'd0);
        check("rst_q", Q, 32'd0);
        check("rst_ade", {30'd0, AdE}, 32'd0);
        @(negedge clk);
        RESET_N = 1'b1;

        // DM word store then byte/half loads
        @(negedge clk);
        acc(SW, 32'h100, 32'h1234_5678);
        check("sw_be", {28'd0, DM_BE}, 32'hF);
        check("sw_dma", DM_A, 32'h100);
        check("sw_ade", {30'd0, AdE}, 32'd0);
        edge_step();
        acc(LB, 32'h103, 32'd0);  check("lb_103", Q, 32'h0000_0012);
        acc(LHU, 32'h102, 32'd0); check("lhu_102", Q, 32'h0000_1234);
        acc(LB, 32'h100, 32'd0);  check("lb_100", Q, 32'h0000_0078);

        acc(SB, 32'h105, 32'h0000_0080);
        check("sb_be", {28'd0, DM_BE}, 32'b0010);
        check("sb_dmd", DM_D, 32'h8080_8080);
        edge_step();
        acc(SH, 32'h106, 32'h0000_BEEF);
        check("sh_be", {28'd0, DM_BE}, 32'b1100);
        check("sh_dmd", DM_D, 32'hBEEF_BEEF);
        edge_step();
        acc(LB, 32'h105, 32'd0);  check("lb_sext", Q, 32'hFFFF_FF80);
        acc(LBU, 32'h105, 32'd0); check("lbu_zext", Q, 32'h0000_0080);
        acc(LH, 32'h106, 32'd0);  check("lh_sext", Q, 32'hFFFF_BEEF);
        acc(LW, 32'h104, 32'd0);  check("lw_104", Q, 32'hBEEF_8000);

        // Address and alignment faults
        acc(LH, 32'h101, 32'd0);
        check("lh_mis_ade", {30'd0, AdE}, 32'd1);
        check("lh_mis_be", {28'd0, DM_BE}, 32'd0);
        acc(SW, 32'h102, 32'hDEAD_BEEF);
        check("sw_mis_ade", {30'd0, AdE}, 32'd2);
        check("sw_mis_be", {28'd0, DM_BE}, 32'd0);
        acc(SW, 32'h7F08, 32'd5); check("sw_count_ade", {30'd0, AdE}, 32'd2);
        acc(SB, 32'h7F00, 32'd1); check("sb_tc_ade", {30'd0, AdE}, 32'd2);
        acc(LW, 32'h3000, 32'd0); check("lw_3000_ade", {30'd0, AdE}, 32'd1);
        acc(LW, 32'h2FFC, 32'd0); check("lw_2ffc_ade", {30'd0, AdE}, 32'd0);
        acc(LW, 32'h7F0C, 32'd0); check("lw_7f0c_ade", {30'd0, AdE}, 32'd1);
`ifdef BRIDGE_TC1_EN
        acc(LW, 32'h7F10, 32'd0); check("lw_tc1_ade", {30'd0, AdE}, 32'd0);
`else
        acc(LW, 32'h7F10, 32'd0); check("lw_tc1_ade", {30'd0, AdE}, 32'd1);
`endif

        // Req suppresses writes
        Req = 1'b1;
        acc(SW, 32'h200, 32'hAAAA_5555);
        check("req_be", {28'd0, DM_BE}, 32'd0);
        edge_step();
        Req = 1'b0;
        acc(LW, 32'h200, 32'd0); check("req_mem", Q, 32'd0);

        // IG acknowledge and passthrough interrupt
        @(negedge clk);
        acc(SW, 32'h7F20, 32'd1);
        check("ig_ack", {31'd0, IG_ACK}, 32'd1);
        edge_step();
        idle();
        check("ig_ack_drop", {31'd0, IG_ACK}, 32'd0);
        acc(LW, 32'h7F20, 32'd0); check("ig_load", Q, 32'd0);
        EXT_IRQ = 1'b1; #1;
        check("ig_irq", {26'd0, HWInt}, 32'h4);
        EXT_IRQ = 1'b0;

        // TC0 one-shot: PRESET=3, CTRL=0x9 written at E0
        @(negedge clk);
        acc(SW, 32'h7F04, 32'd3);
        edge_step();
        acc(SW, 32'h7F00, 32'h9);
        edge_step();                               // E0
        acc(LW, 32'h7F08, 32'd0);
        for (int k = 1; k <= 7; k++) begin
            edge_step();
            if (k == 2) check("os_cnt_e2", Q, 32'd3);
            if (k == 4) begin
                check("os_cnt_e4", Q, 32'd1);
                check("os_irq_e4", {31'd0, HWInt[0]}, 32'd0);
            end
            if (k == 5) check("os_irq_e5", {31'd0, HWInt[0]}, 32'd1);
            if (k == 6) begin
                acc(LW, 32'h7F00, 32'd0);
                check("os_ctrl_e6", Q, 32'h8);
                acc(LW, 32'h7F08, 32'd0);
            end
            if (k == 7) check("os_irq_hold", {31'd0, HWInt[0]}, 32'd1);
        end
        acc(SW, 32'h7F00, 32'h0);
        edge_step();
        check("os_irq_clr", {31'd0, HWInt[0]}, 32'd0);

        // TC0 auto-reload: IRQ pulses at E5 and E10
        acc(SW, 32'h7F00, 32'hB);
        edge_step();                               // E0
        acc(LW, 32'h7F08, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            edge_step();
            check($sformatf("ar_irq_e%0d", k), {31'd0, HWInt[0]},
                  ((k == 5) || (k == 10)) ? 32'd1 : 32'd0);
        end
        check("ar_cnt_e12", Q, 32'd3);

        // Asynchronous reset mid-count
        @(negedge clk);
        RESET_N = 1'b0;
        #1;
        check("arst_count", Q, 32'd0);
        check("arst_hwint", {26'd0, HWInt}, 32'd0);
        acc(LW, 32'h7F00, 32'd0); check("arst_ctrl", Q, 32'd0);
        #2;
        RESET_N = 1'b1;
        acc(LW, 32'h7F08, 32'd0);
        repeat (3) edge_step();
        check("arst_idle", Q, 32'd0);

        // PRESET=0 behaves as PRESET=1
        acc(SW, 32'h7F00, 32'h9);
        edge_step();                               // E0
        acc(LW, 32'h7F08, 32'd0);
        edge_step();
        edge_step();                               // E2: COUNT=1
        check("p0_cnt_e2", Q, 32'd1);
        check("p0_irq_e2", {31'd0, HWInt[0]}, 32'd0);
        edge_step();
        check("p0_irq_e3", {31'd0, HWInt[0]}, 32'd1);

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bridge_tc.md
Name: bridge_tc

Overview:
- System bridge placed directly downstream of the CPU's M stage. It consumes CPU_Req, CPU_BridgeSel_M, CPU_ISLOADSTORE_M, CPU_BRIDGE_A and CPU_BRIDGE_D.
- It returns BRIDGE_Q, BRIDGE_AdE and BRIDGE_HWInt, which the CPU feeds into its exception and interrupt logic.
- It decodes each access to one of three targets: data memory (DM), two timer/counters (TC0, TC1), or the interrupt-generator acknowledge register.
- It contains both timers and performs load extension.

Parameters:
- DM_TOP, 32'h0000_2FFF, last valid DM byte address.
- TC0_BASE, 32'h0000_7F00, TC0 register base.
- TC1_BASE, 32'h0000_7F10, TC1 register base.
- IG_BASE, 32'h0000_7F20, interrupt-generator acknowledge word.

Ports:
- clk  in  1  clock.
- RESET_N  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- Req  in  1  CP0 exception/interrupt request for the current M instruction; suppresses all writes.
- BridgeSel  in  4  access descriptor:
  - [3]: 1 = store, 0 = load.
  - [2]: unsigned load.
  - [1:0]: 00 word, 01 half, 10 byte.
- ISLOADSTORE  in  1  an M-stage memory access is valid.
- A  in  32  byte address.
- D  in  32  store data, right-aligned.
- Q  out  32  extended load data.
- AdE  out  2  00 none, 01 AdEL, 10 AdES.
- HWInt  out  6  {3'b0, IG_IRQ, TC1_IRQ, TC0_IRQ}.
- DM_A  out  32  word-aligned DM address ({A[31:2],2'b00}).
- DM_BE  out  4  DM byte write enables.
- DM_D  out  32  lane-shifted store data.
- DM_Q  in  32  DM read word.
- EXT_IRQ  in  1  external interrupt level.
- IG_ACK  out  1  acknowledge pulse to the interrupt source.

Behaviour:
- Decode is combinational and applies only when ISLOADSTORE=1; otherwise AdE=00, DM_BE=0, IG_ACK=0, Q=0.
- Misalignment raises AdE (AdEL for loads, AdES for stores):
  - word access with A[1:0]!=0;
  - half access with A[0]!=0.
- Address fault (same AdE encoding): address outside DM, TC0 (+0..+B), TC1 (+0..+B) and IG (+0..+3).
- Timer-specific faults:
  - half or byte access to a TC register → AdE;
  - store to TC COUNT (+8) → AdES.
- When AdE!=00 or Req=1, no write is performed: DM_BE=0, no TC register update, IG_ACK=0.
- DM store enables: word → BE=1111; half → 0011<<A[1]*2; byte → 0001<<A[1:0]. DM_D carries the data replicated into the selected lanes.
- Loads:
  - select the word from the decoded target (DM_Q, TC register, or 0 for IG);
  - shift by A[1:0];
  - sign-extend, or zero-extend if BridgeSel[2]=1.
- TC registers:
  - CTRL (+0): [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload), [3] IM; upper bits read 0.
  - PRESET (+4).
  - COUNT (+8), read-only.
- TC FSM states: IDLE, LOAD, CNT, INT. All registers and irq_flag reset to 0; state resets to IDLE.
  - IDLE: EN=1 → LOAD.
  - LOAD: COUNT<=PRESET → CNT.
  - CNT: EN=0 → IDLE. Else, if COUNT>1, COUNT<=COUNT-1. Else COUNT<=0, irq_flag<=1 → INT.
  - INT, mode 00: EN<=0 → IDLE; irq_flag holds.
  - INT, mode 01: irq_flag<=0 → LOAD (one-cycle pulse).
- A CPU write to CTRL clears irq_flag. It takes priority over an FSM EN clear in the same cycle.
- A PRESET write does not affect an in-progress count.
- PRESET=0 behaves as PRESET=1.
- TCn_IRQ = irq_flag & IM, registered.
- IG_IRQ = EXT_IRQ passthrough. A valid store to IG_BASE drives IG_ACK=1 combinationally for that cycle.
- Reset asserted mid-count returns every TC to IDLE with COUNT=0 immediately, without waiting for a clock.

Optional Feature:
- Macro BRIDGE_TC1_EN.
- Defined: TC1 is instantiated as described above.
- Undefined:
  - TC1 is absent;
  - its address range decodes as an address fault (AdEL/AdES);
  - HWInt[1]=0.

Test Plan:
- sw D=0x12345678 to A=0x100, then lb A=0x103 and lhu A=0x102 → DM_BE=1111; Q=0x00000012, then Q=0x00001234.
- lh A=0x101 → AdE=01, DM_BE=0. sw A=0x7F08 → AdE=10. sb A=0x7F00 → AdE=10. lw A=0x3000 → AdE=01.
- TC0 one-shot: write PRESET=3, then CTRL=0x9 at edge E0 → COUNT=3 after E2; TC0_IRQ=1 after E5; EN=0 after E6; IRQ held until CTRL is written.
- TC0 auto-reload: PRESET=3, CTRL=0xB → IRQ is a one-cycle pulse with a 5-cycle period.
- sw to DM with Req=1 → DM_BE=0, memory unchanged. sw to IG_BASE with Req=0 → IG_ACK=1 for one cycle.
- RESET_N low for half a cycle during CNT → state IDLE, COUNT=0, HWInt=0 immediately.
